// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS controller: sequences a shared datapath and counts retired instructions.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes park the FSM in TRAP and raise illegal_op.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op_code,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             JumpAndLink,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             instr_done,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_IMM_WB    = 4'd10,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_JAL       = 4'd11,
        S_TRAP      = 4'd12
`else
        S_JAL       = 4'd11
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        JumpAndLink = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        PCSource    = 2'b00;
        instr_done  = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                op_d    = op_code;
                case (op_code)
                    OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                    OP_RTYPE:                 state_d = S_R_EXEC;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EXEC;
                    OP_JAL:                   state_d = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:                  state_d = S_TRAP;
`else
                    // Unsupported opcode retires as a NOP straight out of decode.
                    default: begin
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end
`endif
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op_q)
                    OP_ANDI: ALUOp = 3'b011;
                    OP_ORI:  ALUOp = 3'b100;
                    default: ALUOp = 3'b000;
                endcase
                state_d = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                PCWrite     = 1'b1;
                PCSource    = 2'b10;
                JumpAndLink = 1'b1;
                RegWrite    = 1'b1;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase

        // Counter sees the unmasked pulse; reset clears it on the same edge anyway.
        count_d = count_q + {{(CNT_W-1){1'b0}}, instr_done};

        if (!reset_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
            MemRead     = 1'b0;
            instr_done  = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_op  = (state_q == S_TRAP);
`endif

endmodule
